// File: rtl/video_mem_arbiter_if.sv
// Host write and scanout read bus of the video memory arbiter.
// The master modport is the host/scanout side; the slave modport is the arbiter.
interface video_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_font;
  logic [7:0]        wr_drop_cnt;

  modport master (
    output wr_addr, wr_data, wr_valid, rd_addr, rd_req,
    input  wr_ready, rd_data, rd_valid, rd_font, wr_drop_cnt
  );

  modport slave (
    input  wr_addr, wr_data, wr_valid, rd_addr, rd_req,
    output wr_ready, rd_data, rd_valid, rd_font, wr_drop_cnt
  );
endinterface

// File: rtl/video_mem_arbiter.sv
// Text-mode video memory: char and font banks behind one address space, a queued host
// write port and a fixed-latency scanout read port that always wins bank arbitration.
module video_mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CHAR_AW     = 13,
  parameter int unsigned FONT_AW     = 12,
  parameter int unsigned SEL_BIT     = 13,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  video_mem_arbiter_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(WFIFO_DEPTH);
  localparam int unsigned MemAW = (CHAR_AW > FONT_AW) ? CHAR_AW : FONT_AW;

  localparam logic [ADDR_W-1:0] SelOne   = {{(ADDR_W-1){1'b0}}, 1'b1} << SEL_BIT;
  // Bits that must be zero for an in-range address of each bank (bank select excluded).
  localparam logic [ADDR_W-1:0] CharMask = ({ADDR_W{1'b1}} << CHAR_AW) & ~SelOne;
  localparam logic [ADDR_W-1:0] FontMask = ({ADDR_W{1'b1}} << FONT_AW) & ~SelOne;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a & (a[SEL_BIT] ? FontMask : CharMask)) == '0;
  endfunction

  logic [DATA_W-1:0] char_mem [2**CHAR_AW];
  logic [DATA_W-1:0] font_mem [2**FONT_AW];
  logic [DATA_W-1:0] char_dout_q, font_dout_q;

  logic              fifo_bank_q  [WFIFO_DEPTH];
  logic [MemAW-1:0]  fifo_baddr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q  [WFIFO_DEPTH];
  logic [PtrW:0]     wptr_q, wptr_d, rptr_q, rptr_d;

  logic              wr_ready_q;
  logic [7:0]        drop_cnt_q;
  logic              rd1_valid_q, rd1_ok_q, rd1_bank_q;
  logic              rd_valid_q, rd_font_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_ok, push, enq, rd_ok, rd_bank, rd_hit;
  logic              empty, full_d, pop;
  logic              head_bank;
  logic [MemAW-1:0]  head_baddr;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    wr_ok      = addr_ok(bus.wr_addr);
    push       = bus.wr_valid & wr_ready_q;
    enq        = push & wr_ok;
    rd_ok      = addr_ok(bus.rd_addr);
    rd_bank    = bus.rd_addr[SEL_BIT];
    rd_hit     = bus.rd_req & rd_ok;
    empty      = (wptr_q == rptr_q);
    head_bank  = fifo_bank_q[rptr_q[PtrW-1:0]];
    head_baddr = fifo_baddr_q[rptr_q[PtrW-1:0]];
    head_data  = fifo_data_q[rptr_q[PtrW-1:0]];
    // The head waits only while a valid read holds its own bank.
    pop        = rst_n & ~empty & ~(rd_hit & (head_bank == rd_bank));
    wptr_d     = wptr_q + {{PtrW{1'b0}}, enq};
    rptr_d     = rptr_q + {{PtrW{1'b0}}, pop};
    full_d     = (wptr_d[PtrW-1:0] == rptr_d[PtrW-1:0]) && (wptr_d[PtrW] != rptr_d[PtrW]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      wr_ready_q  <= 1'b0;
      drop_cnt_q  <= '0;
      rd1_valid_q <= 1'b0;
      rd1_ok_q    <= 1'b0;
      rd1_bank_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_font_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_ready_q <= ~full_d;
      if (push && !wr_ok && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      rd1_valid_q <= bus.rd_req;
      rd1_ok_q    <= rd_ok;
      rd1_bank_q  <= rd_bank;
      rd_valid_q  <= rd1_valid_q;
      if (rd1_valid_q) begin
        rd_data_q <= rd1_ok_q ? (rd1_bank_q ? font_dout_q : char_dout_q) : '0;
        rd_font_q <= rd1_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_bank_q[wptr_q[PtrW-1:0]]  <= bus.wr_addr[SEL_BIT];
      fifo_baddr_q[wptr_q[PtrW-1:0]] <= bus.wr_addr[MemAW-1:0];
      fifo_data_q[wptr_q[PtrW-1:0]]  <= bus.wr_data;
    end
  end

  // Banks are never reset; arbitration keeps read and write on different banks.
  always_ff @(posedge clk) begin
    if (pop && !head_bank) char_mem[head_baddr[CHAR_AW-1:0]] <= head_data;
    if (rd_hit && !rd_bank) char_dout_q <= char_mem[bus.rd_addr[CHAR_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (pop && head_bank) font_mem[head_baddr[FONT_AW-1:0]] <= head_data;
    if (rd_hit && rd_bank) font_dout_q <= font_mem[bus.rd_addr[FONT_AW-1:0]];
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.wr_drop_cnt = drop_cnt_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_font     = rd_font_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter: each task drives one scenario and checks inline.
module tb_video_mem_arbiter;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  video_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  video_mem_arbiter #(
    .ADDR_W(16), .DATA_W(8), .CHAR_AW(13), .FONT_AW(12), .SEL_BIT(13), .WFIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write1(input logic [15:0] a, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  // Issues one read and returns what the bus shows after the issuing edge and one edge later.
  task automatic do_read(input logic [15:0] a, output logic v_early, output logic v,
                         output logic [7:0] d, output logic f);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_req = 1'b0;
    v_early    = bus.rd_valid;
    step();
    v = bus.rd_valid;
    d = bus.rd_data;
    f = bus.rd_font;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    idle(2);
    vectors++;
    if ({bus.wr_ready, bus.rd_valid, bus.rd_font, bus.rd_data, bus.wr_drop_cnt} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b v=%b f=%b d=%h drop=%0d want all zero",
               bus.wr_ready, bus.rd_valid, bus.rd_font, bus.rd_data, bus.wr_drop_cnt);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (bus.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1", bus.wr_ready);
    end
  endtask

  task automatic test_basic();
    logic ve, v, f;
    logic [7:0] d;
    write1(16'h0005, 8'h41);
    write1(16'h2010, 8'h3C);
    idle(3);
    do_read(16'h0005, ve, v, d, f);
    vectors++;
    if ({ve, v, f, d} !== {1'b0, 1'b1, 1'b0, 8'h41}) begin
      miscompares++;
      $display("FAIL basic_char: got early=%b v=%b f=%b d=%h want 0 1 0 41", ve, v, f, d);
    end
    do_read(16'h2010, ve, v, d, f);
    vectors++;
    if ({ve, v, f, d} !== {1'b0, 1'b1, 1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL basic_font: got early=%b v=%b f=%b d=%h want 0 1 1 3c", ve, v, f, d);
    end
  endtask

  task automatic test_read_priority();
    logic ve, v, f;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) write1(16'(i), 8'(8'h10 + i));
    idle(3);
    for (int t = 0; t <= 16; t++) begin
      bus.rd_req   = (t < 16);
      bus.rd_addr  = 16'(t);
      bus.wr_valid = (t < 4);
      bus.wr_addr  = 16'(16'h0100 + t);
      bus.wr_data  = 8'(8'hA0 + t);
      step();
      vectors++;
      if (bus.wr_ready !== ((t < 3) || (t == 16))) begin
        miscompares++;
        $display("FAIL burst_ready t=%0d: got %b want %b", t, bus.wr_ready,
                 ((t < 3) || (t == 16)));
      end
      vectors++;
      if (t == 0) begin
        if (bus.rd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL burst_first_valid: got %b want 0", bus.rd_valid);
        end
      end else if ({bus.rd_valid, bus.rd_font, bus.rd_data} !== {2'b10, 8'(8'h10 + t - 1)}) begin
        miscompares++;
        $display("FAIL burst_read t=%0d: got v=%b f=%b d=%h want 1 0 %h", t, bus.rd_valid,
                 bus.rd_font, bus.rd_data, 8'(8'h10 + t - 1));
      end
    end
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      do_read(16'(16'h0100 + i), ve, v, d, f);
      vectors++;
      if ({v, f, d} !== {2'b10, 8'(8'hA0 + i)}) begin
        miscompares++;
        $display("FAIL drained_write %0d: got v=%b f=%b d=%h want 1 0 %h", i, v, f, d,
                 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_font_reads();
    logic ve, v, f;
    logic [7:0] d;
    for (int t = 0; t <= 8; t++) begin
      bus.rd_req   = (t < 8);
      bus.rd_addr  = 16'h2010;
      bus.wr_valid = (t < 8);
      bus.wr_addr  = 16'(16'h0200 + t);
      bus.wr_data  = 8'(8'hC0 + t);
      step();
      vectors++;
      if (bus.wr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL font_burst_ready t=%0d: got %b want 1", t, bus.wr_ready);
      end
      vectors++;
      if (t == 0) begin
        if (bus.rd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL font_first_valid: got %b want 0", bus.rd_valid);
        end
      end else if ({bus.rd_valid, bus.rd_font, bus.rd_data} !== {2'b11, 8'h3C}) begin
        miscompares++;
        $display("FAIL font_burst t=%0d: got v=%b f=%b d=%h want 1 1 3c", t, bus.rd_valid,
                 bus.rd_font, bus.rd_data);
      end
    end
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    idle(2);
    do_read(16'h0200, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b10, 8'hC0}) begin
      miscompares++;
      $display("FAIL font_burst_wr0: got v=%b f=%b d=%h want 1 0 c0", v, f, d);
    end
    do_read(16'h0207, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b10, 8'hC7}) begin
      miscompares++;
      $display("FAIL font_burst_wr7: got v=%b f=%b d=%h want 1 0 c7", v, f, d);
    end
  endtask

  task automatic test_drops();
    logic ve, v, f;
    logic [7:0] d;
    write1(16'h2000, 8'h5A);
    write1(16'h0000, 8'hA5);
    idle(2);
    write1(16'h3000, 8'hEE);
    write1(16'h8000, 8'hEE);
    idle(2);
    vectors++;
    if ({bus.wr_ready, bus.wr_drop_cnt} !== {1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL drop_two: got rdy=%b cnt=%0d want 1 2", bus.wr_ready, bus.wr_drop_cnt);
    end
    do_read(16'h2000, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b11, 8'h5A}) begin
      miscompares++;
      $display("FAIL drop_font_kept: got v=%b f=%b d=%h want 1 1 5a", v, f, d);
    end
    do_read(16'h0000, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b10, 8'hA5}) begin
      miscompares++;
      $display("FAIL drop_char_kept: got v=%b f=%b d=%h want 1 0 a5", v, f, d);
    end
    do_read(16'h3000, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b11, 8'h00}) begin
      miscompares++;
      $display("FAIL oor_read: got v=%b f=%b d=%h want 1 1 00", v, f, d);
    end
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h8000;
    idle(252);
    vectors++;
    if (bus.wr_drop_cnt !== 8'd254) begin
      miscompares++;
      $display("FAIL drop_254: got %0d want 254", bus.wr_drop_cnt);
    end
    idle(1);
    vectors++;
    if (bus.wr_drop_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL drop_255: got %0d want 255", bus.wr_drop_cnt);
    end
    idle(45);
    bus.wr_valid = 1'b0;
    vectors++;
    if ({bus.wr_ready, bus.wr_drop_cnt} !== {1'b1, 8'd255}) begin
      miscompares++;
      $display("FAIL drop_saturate: got rdy=%b cnt=%0d want 1 255", bus.wr_ready,
               bus.wr_drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic ve, v, f;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) write1(16'(16'h2100 + i), 8'(8'h60 + i));
    idle(3);
    for (int t = 0; t < 6; t++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 16'h2010;
      bus.wr_valid = (t < 4);
      bus.wr_addr  = 16'(16'h2100 + t);
      bus.wr_data  = 8'(8'h70 + t);
      step();
    end
    bus.wr_valid = 1'b0;
    vectors++;
    if (bus.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_full: got rdy=%b want 0", bus.wr_ready);
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if ({bus.wr_ready, bus.rd_valid, bus.rd_font, bus.rd_data, bus.wr_drop_cnt} !== 19'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b v=%b f=%b d=%h drop=%0d want all zero",
               bus.wr_ready, bus.rd_valid, bus.rd_font, bus.rd_data, bus.wr_drop_cnt);
    end
    rst_n      = 1'b1;
    bus.rd_req = 1'b0;
    step();
    vectors++;
    if ({bus.wr_ready, bus.rd_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_after: got rdy=%b v=%b want 1 0", bus.wr_ready, bus.rd_valid);
    end
    idle(2);
    for (int i = 0; i < 4; i++) begin
      do_read(16'(16'h2100 + i), ve, v, d, f);
      vectors++;
      if ({v, f, d} !== {2'b11, 8'(8'h60 + i)}) begin
        miscompares++;
        $display("FAIL mid_lost_write %0d: got v=%b f=%b d=%h want 1 1 %h", i, v, f, d,
                 8'(8'h60 + i));
      end
    end
    do_read(16'h2010, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b11, 8'h3C}) begin
      miscompares++;
      $display("FAIL mid_persist_font: got v=%b f=%b d=%h want 1 1 3c", v, f, d);
    end
    do_read(16'h0100, ve, v, d, f);
    vectors++;
    if ({v, f, d} !== {2'b10, 8'hA0}) begin
      miscompares++;
      $display("FAIL mid_persist_char: got v=%b f=%b d=%h want 1 0 a0", v, f, d);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_read_priority();
    test_font_reads();
    test_drops();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
